// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter fed by CPU stores through a small TX FIFO.
// Latency: a byte pushed at edge E0 drives the start bit from E0+1; a frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: none upstream; a store while the FIFO is full is dropped and sets sticky ovf.
// Optional build macro UART_TX_STATUS_EN adds the rd_data status port and the ovf clear register.
module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] UART_ADDR    = 32'h0002_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [7:0]  wr_data,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        ovf
`ifdef UART_TX_STATUS_EN
  ,
  output logic [31:0] rd_data
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, push_req, push, pop, cnt_end, ovf_clr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign busy      = (state != IDLE) || !empty;
  assign push_req  = we && (addr == UART_ADDR);
  // Full is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign push      = push_req && !fifo_full;
  assign cnt_end   = (cnt == CNT_MAX);

`ifdef UART_TX_STATUS_EN
  localparam logic [31:0] STAT_ADDR = UART_ADDR + 32'd4;
  assign ovf_clr = we && (addr == STAT_ADDR) && wr_data[0];
  assign rd_data = (addr == STAT_ADDR) ? {29'd0, ovf, fifo_full, busy} : 32'd0;
`else
  assign ovf_clr = 1'b0;
`endif

  // Next-state, baud counter, shifter and line value for the framing FSM.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr[AW-1:0]];
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (cnt_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          state_nxt   = DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt_end) begin
          cnt_nxt   = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt_end) begin
          cnt_nxt = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr[AW-1:0]];
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Line level follows the state being entered so tx is a clean register output.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // FSM, counter, shifter and tx registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
    end
  end

  // FIFO pointers; reset discards anything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage needs no reset; contents are only read behind valid pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Sticky overflow flag; a fresh overflow wins over a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (push_req && fifo_full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Covers reset, single frames, address decode, FIFO fill/overflow, back-to-back frames and mid-frame reset.
module tb_uart_tx_mmio;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] UA    = 32'h0002_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [31:0] addr;
  logic [7:0]  wr_data;
  logic        tx, busy, fifo_full, ovf;
`ifdef UART_TX_STATUS_EN
  logic [31:0] rd_data;
`endif

  int errors = 0;
  int checks = 0;

  logic tx_log   [0:255];
  logic busy_log [0:255];

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    logic        sent;
  } vec_t;

  vec_t vecs [9];

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .UART_ADDR   (UA)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .addr     (addr),
    .wr_data  (wr_data),
    .tx       (tx),
    .busy     (busy),
    .fifo_full(fifo_full),
    .ovf      (ovf)
`ifdef UART_TX_STATUS_EN
    ,
    .rd_data  (rd_data)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected line level m cycles into a frame (m=0 is the first start-bit cycle).
  function automatic logic exp_bit(input logic [7:0] b, input int m);
    logic [2:0] bi;
    bi = 3'((m - CPB) / CPB);
    if (m < CPB) return 1'b0;
    if (m < 9 * CPB) return b[bi];
    return 1'b1;
  endfunction

  // One store cycle; entered and left 1 unit after a rising edge.
  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wr_data = d;
    @(posedge clk); #1;
    we = 1'b0; addr = 32'd0; wr_data = 8'd0;
  endtask

  task automatic chk_frame(input logic [7:0] b, input int id);
    for (int m = 0; m < 10 * CPB; m++) begin
      @(posedge clk); #1;
      check($sformatf("v%0d_tx_m%0d", id, m), 32'(tx), 32'(exp_bit(b, m)));
      if (m == 0) check($sformatf("v%0d_busy_start", id), 32'(busy), 32'd1);
      if (m == 10 * CPB - 1) check($sformatf("v%0d_busy_stop", id), 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    check($sformatf("v%0d_busy_done", id), 32'(busy), 32'd0);
    check($sformatf("v%0d_tx_done", id), 32'(tx), 32'd1);
  endtask

  task automatic chk_quiet(input string nm, input int cycles);
    int bad;
    bad = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check(nm, 32'(bad), 32'd0);
  endtask

  initial begin
    logic exp_ovf_after_clr;
    logic [7:0] eb;
    logic       ev;

    rst_n = 1'b0; we = 1'b0; addr = 32'd0; wr_data = 8'd0;
    vecs[0] = '{UA,                  8'h55, 1'b1};
    vecs[1] = '{UA,                  8'h00, 1'b1};
    vecs[2] = '{UA,                  8'hFF, 1'b1};
    vecs[3] = '{UA,                  8'hA5, 1'b1};
    vecs[4] = '{UA + 32'd8,          8'hAA, 1'b0};
    vecs[5] = '{32'h0001_0000,       8'hAA, 1'b0};
    vecs[6] = '{UA | 32'h8000_0000,  8'h3C, 1'b0};
    vecs[7] = '{UA + 32'd1,          8'h5A, 1'b0};
    vecs[8] = '{UA + 32'd4,          8'hAA, 1'b0};

    // Reset state and a quiet line afterwards.
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    chk_quiet("idle_100", 100);

    // Table of single stores: sent bytes must frame exactly, others must be ignored.
    for (int i = 0; i < 9; i++) begin
      wr(vecs[i].a, vecs[i].d);
      if (vecs[i].sent) chk_frame(vecs[i].d, i);
      else chk_quiet($sformatf("v%0d_ignored", i), 10 * CPB + 4);
    end

    // Fill the FIFO on consecutive edges, overflow it, and log the back-to-back frames.
`ifdef UART_TX_STATUS_EN
    exp_ovf_after_clr = 1'b0;
`else
    exp_ovf_after_clr = 1'b1;
`endif
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          we = 1'b1; addr = UA; wr_data = 8'(i);
          @(posedge clk); #1;
          if (i == 4) check("fill_full_after4", 32'(fifo_full), 32'd0);
          if (i == 5) begin
            check("fill_full_after5", 32'(fifo_full), 32'd1);
            check("fill_ovf_after5", 32'(ovf), 32'd0);
          end
        end
        we = 1'b0; addr = 32'd0; wr_data = 8'd0;
        check("fill_ovf_after6", 32'(ovf), 32'd1);
        check("fill_full_after6", 32'(fifo_full), 32'd1);
        addr = UA + 32'd4;
        #1;
`ifdef UART_TX_STATUS_EN
        check("stat_rd", rd_data, 32'h7);
`endif
        we = 1'b1; wr_data = 8'h01;
        @(posedge clk); #1;
        we = 1'b0; addr = 32'd0; wr_data = 8'd0;
        check("stat_clr_ovf", 32'(ovf), 32'(exp_ovf_after_clr));
        #1;
`ifdef UART_TX_STATUS_EN
        check("stat_rd_other_addr", rd_data, 32'd0);
`endif
        wr(UA, 8'h77);
        check("reovf_ovf", 32'(ovf), 32'd1);
        check("reovf_full", 32'(fifo_full), 32'd1);
      end
      begin
        for (int k = 1; k <= 203; k++) begin
          @(posedge clk); #1;
          tx_log[k]   = tx;
          busy_log[k] = busy;
        end
      end
    join
    for (int k = 1; k <= 203; k++) begin
      if (k < 2 || k >= 202) begin
        ev = 1'b1;
      end else begin
        eb = 8'((k - 2) / (10 * CPB) + 1);
        ev = exp_bit(eb, (k - 2) % (10 * CPB));
      end
      check($sformatf("b2b_tx_k%0d", k), 32'(tx_log[k]), 32'(ev));
    end
    check("b2b_busy_last", 32'(busy_log[201]), 32'd1);
    check("b2b_busy_done", 32'(busy_log[202]), 32'd0);

    // Reset in the middle of data bit 3 with two bytes still queued.
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; addr = UA;
      wr_data = (i == 0) ? 8'hF7 : ((i == 1) ? 8'h12 : 8'h34);
      @(posedge clk); #1;
    end
    we = 1'b0; addr = 32'd0; wr_data = 8'd0;
    repeat (16) @(posedge clk);
    #1;
    check("mid_tx_bit3", 32'(tx), 32'd0);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_ovf_sticky", 32'(ovf), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_full", 32'(fifo_full), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_quiet("post_rst_quiet", 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
